// File: rtl/cache_way_ctrl_if.sv
// Bundle of the CPU-side request, tag/data/valid/dirty array controls and
// memory handshake signals around the 4-way cache way controller.
interface cache_way_ctrl_if #(
    parameter int INDEX_W = 4
);
    // CPU request side
    logic               cpu_read;
    logic               cpu_write;
    logic [INDEX_W-1:0] set_idx;
    logic               cpu_resp;

    // Array lookups for the indexed set
    logic [3:0]         way_hit;
    logic [3:0]         way_valid;
    logic [3:0]         way_dirty;

    // Array write / mux controls
    logic [1:0]         way_sel;
    logic [3:0]         array_we;
    logic               valid_in;
    logic               dirty_in;
    logic               load_from_mem;
    logic               addr_sel;

    // Memory handshake
    logic               mem_read;
    logic               mem_write;
    logic               mem_resp;

    // Environment side: requester, arrays and memory
    modport master (
        output cpu_read, cpu_write, set_idx,
        output way_hit, way_valid, way_dirty,
        output mem_resp,
        input  cpu_resp, way_sel, array_we, valid_in, dirty_in,
        input  load_from_mem, addr_sel, mem_read, mem_write
    );

    // Controller side
    modport slave (
        input  cpu_read, cpu_write, set_idx,
        input  way_hit, way_valid, way_dirty,
        input  mem_resp,
        output cpu_resp, way_sel, array_we, valid_in, dirty_in,
        output load_from_mem, addr_sel, mem_read, mem_write
    );
endinterface

// File: rtl/cache_way_ctrl.sv
// Control FSM for a 4-way set-associative cache: hit/miss sequencing,
// active-way selection, per-set tree-PLRU victim choice and the
// writeback/allocate handshakes with memory.
module cache_way_ctrl #(
    parameter int INDEX_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    cache_way_ctrl_if.slave    bus
);
    localparam int SETS = 2 ** INDEX_W;

    typedef enum logic [1:0] {
        IDLE,
        COMPARE,
        WRITEBACK,
        ALLOCATE
    } state_t;

    state_t     state_q, state_d;
    logic [1:0] victim_q, victim_d;
    logic [2:0] plru_q [SETS];

    logic [2:0] plru_cur;
    logic [2:0] plru_next;
    logic       plru_upd;
    logic [1:0] hit_way;
    logic [1:0] miss_victim;

    logic       cpu_resp;
    logic [1:0] way_sel;
    logic [3:0] array_we;
    logic       valid_in;
    logic       dirty_in;
    logic       load_from_mem;
    logic       addr_sel;
    logic       mem_read;
    logic       mem_write;

    // Way selection: lowest hitting way, and the miss victim (lowest invalid
    // way first, otherwise the tree-PLRU choice for the indexed set).
    always_comb begin
        // NOTE: every variable gets a value before any branch, so no path
        // through the block leaves one unassigned and no latch is inferred.
        plru_cur    = plru_q[bus.set_idx];
        hit_way     = 2'd0;
        miss_victim = {plru_cur[0], plru_cur[0] ? plru_cur[2] : plru_cur[1]};
        // Descending scan so the lowest index wins.
        for (int i = 3; i >= 0; i--) begin
            if (bus.way_hit[i]) begin
                hit_way = 2'(i);
            end
            if (!bus.way_valid[i]) begin
                miss_victim = 2'(i);
            end
        end
        // Tree update for an access to hit_way: point both levels away from it.
        plru_next    = plru_cur;
        plru_next[0] = ~hit_way[1];
        if (!hit_way[1]) begin
            plru_next[1] = ~hit_way[0];
        end else begin
            plru_next[2] = ~hit_way[0];
        end
    end

    // Next-state and output decode; every output defaults to 0.
    always_comb begin
        state_d       = state_q;
        victim_d      = victim_q;
        plru_upd      = 1'b0;
        cpu_resp      = 1'b0;
        way_sel       = 2'd0;
        array_we      = 4'b0000;
        valid_in      = 1'b0;
        dirty_in      = 1'b0;
        load_from_mem = 1'b0;
        addr_sel      = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.cpu_read || bus.cpu_write) begin
                    state_d = COMPARE;
                end
            end

            COMPARE: begin
                if (|bus.way_hit) begin
                    way_sel  = hit_way;
                    cpu_resp = 1'b1;
                    plru_upd = 1'b1;
                    // A write wins when both request lines are up.
                    if (bus.cpu_write) begin
                        array_we = 4'b0001 << hit_way;
                        valid_in = 1'b1;
                        dirty_in = 1'b1;
                    end
                    state_d = IDLE;
                end else begin
                    victim_d = miss_victim;
                    if (bus.way_valid[miss_victim] && bus.way_dirty[miss_victim]) begin
                        state_d = WRITEBACK;
                    end else begin
                        state_d = ALLOCATE;
                    end
                end
            end

            WRITEBACK: begin
                way_sel   = victim_q;
                addr_sel  = 1'b1;
                mem_write = 1'b1;
                if (bus.mem_resp) begin
                    state_d = ALLOCATE;
                end
            end

            ALLOCATE: begin
                way_sel       = victim_q;
                load_from_mem = 1'b1;
                mem_read      = 1'b1;
                // Fill lands with the burst; the re-compare then hits.
                if (bus.mem_resp) begin
                    array_we = 4'b0001 << victim_q;
                    valid_in = 1'b1;
                    state_d  = COMPARE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and victim registers; reset forces IDLE so every output drops at once.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: clocked state uses non-blocking assignments so all registers
        // update together from pre-edge values, independent of block order.
        if (rst) begin
            state_q  <= IDLE;
            victim_q <= 2'd0;
        end else begin
            state_q  <= state_d;
            victim_q <= victim_d;
        end
    end

    // Per-set PLRU bits, updated only by hits in COMPARE.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: the PLRU table is a small flop array, not RAM, so it can and
        // must be cleared by reset; replacement order restarts from way 0.
        if (rst) begin
            for (int s = 0; s < SETS; s++) begin
                plru_q[s] <= 3'b000;
            end
        end else if (plru_upd) begin
            plru_q[bus.set_idx] <= plru_next;
        end
    end

    assign bus.cpu_resp      = cpu_resp;
    assign bus.way_sel       = way_sel;
    assign bus.array_we      = array_we;
    assign bus.valid_in      = valid_in;
    assign bus.dirty_in      = dirty_in;
    assign bus.load_from_mem = load_from_mem;
    assign bus.addr_sel      = addr_sel;
    assign bus.mem_read      = mem_read;
    assign bus.mem_write     = mem_write;

endmodule
